// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pkg : opcode and sequencer state types shared by ALU and FSM      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package alu_pkg;

    localparam int REG_W = 8;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_NOT = 3'd4,
        OP_XOR = 3'd5,
        OP_ROL = 3'd6,
        OP_ROR = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_core : combinational 8-bit ALU, carry = carry-out / borrow / bit  |
// | rotated out, zero = result is zero. Revision: 1.0                     |
// +----------------------------------------------------------------------+
module alu_core
    import alu_pkg::*;
(
    input  logic [2:0]       op,
    input  logic [REG_W-1:0] a,
    input  logic [REG_W-1:0] b,
    output logic [REG_W-1:0] out,
    output logic             carry,
    output logic             zero
);

    logic [REG_W:0] sum_w;

    always_comb begin
        sum_w = '0;
        out   = '0;
        carry = 1'b0;
        case (alu_op_e'(op))
            OP_ADD: begin
                sum_w = {1'b0, a} + {1'b0, b};
                out   = sum_w[REG_W-1:0];
                carry = sum_w[REG_W];
            end
            OP_SUB: begin
                // Carry reports a borrow (a < b unsigned).
                sum_w = {1'b0, a} - {1'b0, b};
                out   = sum_w[REG_W-1:0];
                carry = sum_w[REG_W];
            end
            OP_AND: out = a & b;
            OP_OR:  out = a | b;
            OP_NOT: out = ~a;
            OP_XOR: out = a ^ b;
            OP_ROL: begin
                out   = {a[REG_W-2:0], a[REG_W-1]};
                carry = a[REG_W-1];
            end
            OP_ROR: begin
                out   = {a[0], a[REG_W-1:1]};
                carry = a[0];
            end
            default: out = '0;
        endcase
        zero = (out == '0);
    end

endmodule : alu_core
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_regfile : NUM_REGS x 8 registers, one write port, two operand     |
// | read ports and a debug read port. Revision: 1.0                       |
// +----------------------------------------------------------------------+
module alu_regfile
    import alu_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [REG_W-1:0] wdata,
    input  logic [IDX_W-1:0] raddr_a,
    output logic [REG_W-1:0] rdata_a,
    input  logic [IDX_W-1:0] raddr_b,
    output logic [REG_W-1:0] rdata_b,
    input  logic [IDX_W-1:0] dbg_addr,
    output logic [REG_W-1:0] dbg_data
);

    logic [NUM_REGS-1:0][REG_W-1:0] regs_q;
    logic [NUM_REGS-1:0][REG_W-1:0] regs_d;

    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (we && (waddr == IDX_W'(i))) begin
                regs_d[i] = wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reads return the pre-write value, so rd == rs sees the old operand.
    assign rdata_a  = regs_q[raddr_a];
    assign rdata_b  = regs_q[raddr_b];
    assign dbg_data = regs_q[dbg_addr];

endmodule : alu_regfile
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_sequencer : IDLE/EXEC/DONE request sequencer driving an external  |
// | ALU and owning the register file and flags. Revision: 1.0            |
// +----------------------------------------------------------------------+
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [IDX_W-1:0] req_rd,
    input  logic [IDX_W-1:0] req_rs,
    input  logic             req_imm_en,
    input  logic [REG_W-1:0] req_imm,
    input  logic             req_wb,
    output logic [2:0]       alu_op,
    output logic [REG_W-1:0] alu_a,
    output logic [REG_W-1:0] alu_b,
    input  logic [REG_W-1:0] alu_out,
    input  logic             alu_carry,
    input  logic             alu_zero,
    output logic             done,
    output logic             flag_c,
    output logic             flag_z,
    input  logic [IDX_W-1:0] dbg_addr,
    output logic [REG_W-1:0] dbg_data
);

    seq_state_e       state_q,  state_d;
    logic [2:0]       op_q,     op_d;
    logic [IDX_W-1:0] rd_q,     rd_d;
    logic [IDX_W-1:0] rs_q,     rs_d;
    logic             imm_en_q, imm_en_d;
    logic [REG_W-1:0] imm_q,    imm_d;
    logic             wb_q,     wb_d;
    logic             flag_c_q, flag_c_d;
    logic             flag_z_q, flag_z_d;
    logic             done_q,   done_d;
    logic             ready_q,  ready_d;

    logic             in_exec_w;
    logic             we_w;
    logic [REG_W-1:0] rd_data_w;
    logic [REG_W-1:0] rs_data_w;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        rs_d     = rs_q;
        imm_en_d = imm_en_q;
        imm_d    = imm_q;
        wb_d     = wb_q;
        flag_c_d = flag_c_q;
        flag_z_d = flag_z_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    op_d     = req_op;
                    rd_d     = req_rd;
                    rs_d     = req_rs;
                    imm_en_d = req_imm_en;
                    imm_d    = req_imm;
                    wb_d     = req_wb;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                flag_c_d = alu_carry;
                flag_z_d = alu_zero;
                state_d  = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Status outputs are registered from the next state so they line up with it.
        done_d  = (state_d == ST_DONE);
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            rs_q     <= '0;
            imm_en_q <= 1'b0;
            imm_q    <= '0;
            wb_q     <= 1'b0;
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            rs_q     <= rs_d;
            imm_en_q <= imm_en_d;
            imm_q    <= imm_d;
            wb_q     <= wb_d;
            flag_c_q <= flag_c_d;
            flag_z_q <= flag_z_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign in_exec_w = (state_q == ST_EXEC);
    assign we_w      = in_exec_w && wb_q;

    alu_regfile #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we_w),
        .waddr    (rd_q),
        .wdata    (alu_out),
        .raddr_a  (rd_q),
        .rdata_a  (rd_data_w),
        .raddr_b  (rs_q),
        .rdata_b  (rs_data_w),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    assign alu_op    = in_exec_w ? op_q : 3'd0;
    assign alu_a     = in_exec_w ? rd_data_w : '0;
    assign alu_b     = in_exec_w ? (imm_en_q ? imm_q : rs_data_w) : '0;
    assign req_ready = ready_q;
    assign done      = done_q;
    assign flag_c    = flag_c_q;
    assign flag_z    = flag_z_q;

endmodule : alu_sequencer
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_sequencer : directed bench, sequencer plus real ALU            |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [1:0] req_rd;
    logic [1:0] req_rs;
    logic       req_imm_en;
    logic [7:0] req_imm;
    logic       req_wb;
    logic [2:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_out;
    logic       alu_carry;
    logic       alu_zero;
    logic       done;
    logic       flag_c;
    logic       flag_z;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;

    int n_vec = 0;
    int n_err = 0;
    int n_acc = 0;
    int acc_base;

    always #5 clk = ~clk;

    alu_sequencer #(.NUM_REGS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_rd     (req_rd),
        .req_rs     (req_rs),
        .req_imm_en (req_imm_en),
        .req_imm    (req_imm),
        .req_wb     (req_wb),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_out    (alu_out),
        .alu_carry  (alu_carry),
        .alu_zero   (alu_zero),
        .done       (done),
        .flag_c     (flag_c),
        .flag_z     (flag_z),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    alu_core u_alu (
        .op    (alu_op),
        .a     (alu_a),
        .b     (alu_b),
        .out   (alu_out),
        .carry (alu_carry),
        .zero  (alu_zero)
    );

    always @(posedge clk) begin
        if (rst_n && req_valid && req_ready) n_acc <= n_acc + 1;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reg_is(input logic [1:0] idx, input logic [7:0] exp, input string tag);
        dbg_addr = idx;
        #1;
        check(tag, dbg_data, exp);
    endtask

    // Drive a request at a negedge; return just after the accepting edge with valid low.
    task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                         input logic imm_en, input logic [7:0] imm, input logic wb);
        @(negedge clk);
        req_op = op; req_rd = rd; req_rs = rs;
        req_imm_en = imm_en; req_imm = imm; req_wb = wb;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_op = 3'd0; req_rd = 2'd0; req_rs = 2'd0; req_imm = 8'h00; req_wb = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_rd = 2'd0; req_rs = 2'd0;
        req_imm_en = 1'b0; req_imm = 8'h00; req_wb = 1'b0; dbg_addr = 2'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        for (int i = 0; i < 4; i++) reg_is(2'(i), 8'h00, "rst_reg");
        check("rst_flag_c", {7'd0, flag_c}, 8'h00);
        check("rst_flag_z", {7'd0, flag_z}, 8'h00);
        check("rst_ready",  {7'd0, req_ready}, 8'h01);
        check("rst_done",   {7'd0, done}, 8'h00);
        check("rst_alu_a",  alu_a, 8'h00);

        // OR r1,#F0 with full latency walk
        issue(3'd3, 2'd1, 2'd0, 1'b1, 8'hF0, 1'b1);
        @(negedge clk);
        check("or_exec_op",    {5'd0, alu_op}, 8'h03);
        check("or_exec_b",     alu_b, 8'hF0);
        check("or_exec_done",  {7'd0, done}, 8'h00);
        check("or_exec_ready", {7'd0, req_ready}, 8'h00);
        @(negedge clk);
        reg_is(2'd1, 8'hF0, "or_r1");
        check("or_c",    {7'd0, flag_c}, 8'h00);
        check("or_z",    {7'd0, flag_z}, 8'h00);
        check("or_done", {7'd0, done}, 8'h01);
        check("or_idle_op", {5'd0, alu_op}, 8'h00);
        @(negedge clk);
        check("or_done_end", {7'd0, done}, 8'h00);
        check("or_ready",    {7'd0, req_ready}, 8'h01);

        // ADD r1,#20 : F0 + 20 = 110
        issue(3'd0, 2'd1, 2'd0, 1'b1, 8'h20, 1'b1);
        repeat (2) @(negedge clk);
        reg_is(2'd1, 8'h10, "add_r1");
        check("add_c", {7'd0, flag_c}, 8'h01);
        check("add_z", {7'd0, flag_z}, 8'h00);
        @(negedge clk);

        // SUB r1,#10 flags only
        issue(3'd1, 2'd1, 2'd0, 1'b1, 8'h10, 1'b0);
        repeat (2) @(negedge clk);
        reg_is(2'd1, 8'h10, "sub_r1_kept");
        check("sub_c", {7'd0, flag_c}, 8'h00);
        check("sub_z", {7'd0, flag_z}, 8'h01);
        @(negedge clk);

        // XOR r3,r1 : 00 ^ 10
        issue(3'd5, 2'd3, 2'd1, 1'b0, 8'hFF, 1'b1);
        repeat (2) @(negedge clk);
        reg_is(2'd3, 8'h10, "xor_r3");
        check("xor_z", {7'd0, flag_z}, 8'h00);
        @(negedge clk);

        // ADD r1,r1 : both operands pre-write 10
        issue(3'd0, 2'd1, 2'd1, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        check("addrr_a", alu_a, 8'h10);
        check("addrr_b", alu_b, 8'h10);
        @(negedge clk);
        reg_is(2'd1, 8'h20, "addrr_r1");
        check("addrr_c", {7'd0, flag_c}, 8'h00);
        @(negedge clk);

        // OR r2,#81 then ROL r2 held valid through EXEC/DONE
        acc_base = n_acc;
        @(negedge clk);
        req_op = 3'd3; req_rd = 2'd2; req_rs = 2'd0; req_imm_en = 1'b1;
        req_imm = 8'h81; req_wb = 1'b1; req_valid = 1'b1;
        @(posedge clk);
        #1 req_op = 3'd6; req_imm_en = 1'b0; req_imm = 8'h00;
        @(negedge clk);
        @(negedge clk);
        reg_is(2'd2, 8'h81, "hold_or_r2");
        @(negedge clk);
        check("hold_acc_before", 8'(n_acc - acc_base), 8'h01);
        check("hold_ready_idle", {7'd0, req_ready}, 8'h01);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rol_exec_op", {5'd0, alu_op}, 8'h06);
        check("rol_exec_a",  alu_a, 8'h81);
        @(negedge clk);
        reg_is(2'd2, 8'h03, "rol_r2");
        check("rol_c", {7'd0, flag_c}, 8'h01);
        check("rol_z", {7'd0, flag_z}, 8'h00);
        @(negedge clk);
        @(negedge clk);
        check("hold_acc_total", 8'(n_acc - acc_base), 8'h02);

        // Reset during EXEC of ADD r0,#05
        issue(3'd0, 2'd0, 2'd0, 1'b1, 8'h05, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_alu_a",  alu_a, 8'h00);
        check("abort_alu_b",  alu_b, 8'h00);
        check("abort_done",   {7'd0, done}, 8'h00);
        check("abort_flag_c", {7'd0, flag_c}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        reg_is(2'd0, 8'h00, "abort_r0");
        reg_is(2'd2, 8'h00, "abort_r2");
        check("abort_ready", {7'd0, req_ready}, 8'h01);
        @(negedge clk);
        check("abort_done2", {7'd0, done}, 8'h00);
        check("abort_flag_z", {7'd0, flag_z}, 8'h00);
        check("abort_ready2", {7'd0, req_ready}, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_alu_sequencer
`default_nettype wire

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: NUM_REGS, 4, number of 8-bit general registers (fixed power of two; index width = 2).
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  sequencer can accept a request.
REQ-007 req_op  in  3  ALU opcode (ADD,SUB,AND,OR,NOT,XOR,ROL,ROR = 0..7).
REQ-008 req_rd  in  2  destination and operand-A register index.
REQ-009 req_rs  in  2  operand-B register index.
REQ-010 req_imm_en  in  1  operand B from req_imm instead of register.
REQ-011 req_imm  in  8  immediate operand.
REQ-012 req_wb  in  1  1 = write result to rd; 0 = flags only (compare/test).
REQ-013 alu_op / alu_a / alu_b  out  3/8/8  operands driven to the external ALU.
REQ-014 alu_out / alu_carry / alu_zero  in  8/1/1  combinational ALU results.
REQ-015 done  out  1  one-cycle pulse on completion.
REQ-016 flag_c / flag_z  out  1/1  registered carry and zero flags.
REQ-017 dbg_addr  in  2 / dbg_data  out  8  combinational register read port.

Function
REQ-018 FSM states IDLE, EXEC, DONE; req_ready SHALL be 1 only in IDLE.
REQ-019 req_valid && req_ready at an edge SHALL capture op, rd, rs, imm_en, imm, wb and move IDLE->EXEC.
REQ-020 In EXEC: alu_op = captured op; alu_a = regs[rd]; alu_b = imm_en ? imm : regs[rs].
REQ-021 Outside EXEC, alu_op, alu_a and alu_b SHALL be 0.
REQ-022 Edge ending EXEC: flag_c <= alu_carry, flag_z <= alu_zero; if wb, regs[rd] <= alu_out; state -> DONE.
REQ-023 done = 1 exactly in DONE; DONE -> IDLE unconditionally.
REQ-024 Latency: accept at edge N, write/flag update at edge N+1, done high in cycle N+1..N+2, ready again in cycle after edge N+2; max throughput 1 request per 3 cycles.
REQ-025 All 8 ops update both flags; no op preserves the old flags.
REQ-026 req_valid while req_ready = 0 SHALL be ignored; the requester holds the request stable until accepted.
REQ-027 rd == rs is legal; both operands read the pre-write value.
REQ-028 dbg_data = regs[dbg_addr]; a write becomes visible only after its edge.
REQ-029 Captured request fields SHALL NOT change between accept and DONE regardless of req_* inputs.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, all regs 0, flag_c = flag_z = 0, done = 0, alu_* outputs 0.
REQ-031 Reset asserted during EXEC or DONE SHALL abort with no register or flag write and no done pulse.
REQ-032 After rst_n deasserts, req_ready = 1 on the first cycle.

Structure
REQ-033 Package alu_pkg SHALL hold the opcode enum (ADD..ROR, 3-bit, 0..7) and the sequencer state enum; the ALU shares the opcode enum.
REQ-034 Register storage SHALL be sub-module alu_regfile (NUM_REGS x 8, one write port, two read ports plus debug read port, async reset).
REQ-035 The ALU is instantiated beside alu_sequencer at top level, not inside it.

Verification (bench connects the real ALU)
REQ-036 Reset -> dbg_data 0 for all addresses, flags 0, req_ready 1, done 0.
REQ-037 OR r1,#0xF0 (wb = 1) from reset -> r1 = 0xF0, C = 0, Z = 0, done pulse exactly one cycle after the write edge.
REQ-038 ADD r1,#0x20 with r1 = 0xF0 -> r1 = 0x10, C = 1, Z = 0.
REQ-039 SUB r1,#0x10, wb = 0, with r1 = 0x10 -> r1 stays 0x10, Z = 1, C = 0.
REQ-040 req_valid held high with ROL r2 through EXEC/DONE of a prior request -> exactly one extra accept, made on the next IDLE cycle.
REQ-041 rst_n pulsed low during EXEC of ADD r0,#0x05 -> r0 = 0, flags 0, no done, state IDLE.
